// File: rtl/eval_scheduler.sv
// Two-requester round-robin front end for the eval datapath: credit-limited issue,
// result tracking into a tagged FIFO, and sleep/wake control of the datapath clock gate.
module eval_scheduler #(
  parameter int DW          = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_kernel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_kernel,
  output logic [DW-1:0] eval_data_in1,
  output logic [DW-1:0] eval_data_in2,
  output logic          eval_kernel_enable,
  output logic          eval_gate_en,
  input  logic [DW-1:0] eval_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  output logic          busy
);

  localparam logic [1:0] ST_SLEEP = 2'd0;
  localparam logic [1:0] ST_WAKE  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic [1:0]    state;
  logic [IW-1:0] idle_cnt;
  logic          last_grant;
  logic          s1_v, s2_v, s1_src, s2_src;
  logic          grant0, grant1, accept, any_valid, can_accept;
  logic [CW:0]   inflight;

  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic          fifo_src  [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count;
  logic          push, pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credit counts every result already owed to the FIFO, so a full FIFO can never be overrun.
  assign inflight   = (CW+1)'(fifo_count) + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign can_accept = (state == ST_RUN) && (inflight < (CW+1)'(FIFO_DEPTH));
  assign any_valid  = req0_valid || req1_valid;

  // NOTE: every output of a combinational block gets a default first; otherwise the
  // unassigned paths keep their old value and synthesis infers a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept     = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SLEEP;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_SLEEP: if (any_valid) state <= ST_WAKE;
        ST_WAKE:  state <= ST_RUN;
        ST_RUN: begin
          if (accept || s1_v || s2_v) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
            if (!any_valid) begin
              state    <= ST_SLEEP;
              idle_cnt <= '0;
            end
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= ST_SLEEP;
      endcase
    end
  end

  // Issue stage and result-tracking pipeline; the datapath itself supplies the middle register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v               <= 1'b0;
      s2_v               <= 1'b0;
      s1_src             <= 1'b0;
      s2_src             <= 1'b0;
      last_grant         <= 1'b1;
      eval_data_in1      <= '0;
      eval_data_in2      <= '0;
      eval_kernel_enable <= 1'b0;
    end else begin
      s1_v   <= accept;
      s2_v   <= s1_v;
      s2_src <= s1_src;
      if (accept) begin
        s1_src             <= grant1;
        last_grant         <= grant1;
        eval_data_in1      <= grant1 ? req1_a : req0_a;
        eval_data_in2      <= grant1 ? req1_b : req0_b;
        eval_kernel_enable <= grant1 ? req1_kernel : req0_kernel;
      end else begin
        eval_kernel_enable <= 1'b0;
      end
    end
  end

  assign push = s2_v;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; only the pointers and count are, and the head is masked
  // with out_valid so stale entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= eval_result;
      fifo_src[wr_ptr]  <= s2_src;
    end
  end

  assign out_valid    = (fifo_count != '0);
  assign out_data     = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_src      = out_valid && fifo_src[rd_ptr];
  assign eval_gate_en = (state != ST_SLEEP);
  assign busy         = (state != ST_SLEEP) || s1_v || s2_v || (fifo_count != '0);

endmodule

// File: tb/tb_eval_scheduler.sv
// Self-checking bench for eval_scheduler: attached datapath model, result scoreboard,
// directed timing steps followed by randomized traffic.
module tb_eval_scheduler;

  localparam int DW   = 8;
  localparam int FD   = 4;
  localparam int IDLE = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_kernel;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_kernel;
  logic [DW-1:0] req1_a, req1_b;
  logic [DW-1:0] eval_data_in1, eval_data_in2;
  logic          eval_kernel_enable, eval_gate_en;
  logic [DW-1:0] eval_result = '0;
  logic          out_valid, out_ready, out_src, busy;
  logic [DW-1:0] out_data;

  eval_scheduler #(.DW(DW), .FIFO_DEPTH(FD), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_kernel(req0_kernel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_kernel(req1_kernel),
    .eval_data_in1(eval_data_in1), .eval_data_in2(eval_data_in2),
    .eval_kernel_enable(eval_kernel_enable), .eval_gate_en(eval_gate_en),
    .eval_result(eval_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath: ROM[a] (when kernel) + ~b + a, registered while the clock gate is open.
  function automatic logic [DW-1:0] eval_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic k);
    logic [DW-1:0] rom_v;
    rom_v = k ? DW'(32'(a) * 32 + 2) : '0;
    return rom_v + ~b + a;
  endfunction

  always @(posedge clk)
    if (eval_gate_en) eval_result <= eval_ref(eval_data_in1, eval_data_in2, eval_kernel_enable);

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    s_cyc;
  int    n_acc    = 0;
  logic  last_g   = 1'b1;
  logic  s_r0, s_r1, s_ov, s_osrc, s_gate, s_busy;
  logic [DW-1:0] s_od, s_in1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller drives inputs just after a posedge; this samples, scores, and advances one cycle.
  task automatic tick();
    item_t it;
    int    n_start;
    #1;
    s_cyc  = cyc;
    s_r0   = req0_ready;
    s_r1   = req1_ready;
    s_ov   = out_valid;
    s_od   = out_data;
    s_osrc = out_src;
    s_gate = eval_gate_en;
    s_busy = busy;
    s_in1  = eval_data_in1;
    if (!rst) begin
      n_start = sb.size();
      if (out_valid && out_ready) begin
        check("out_valid_vs_model", 32'(out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
          it = sb.pop_front();
          check("out_data", 32'(out_data), 32'(it.data));
          check("out_src", 32'(out_src), 32'(it.src));
        end
      end
      if (req0_ready || req1_ready) begin
        check("grant_count", 32'(req0_ready) + 32'(req1_ready), 1);
        check("ready_within_credit", 32'(req0_ready || req1_ready), 32'(n_start < FD));
        if (req0_ready) check("ready0_without_valid", 32'(req0_valid), 1);
        if (req1_ready) check("ready1_without_valid", 32'(req1_valid), 1);
        if (req0_valid && req1_valid) check("rr_grant", 32'(req1_ready), 32'(!last_g));
        it.src  = req1_ready;
        it.data = req1_ready ? eval_ref(req1_a, req1_b, req1_kernel)
                             : eval_ref(req0_a, req0_b, req0_kernel);
        sb.push_back(it);
        last_g = req1_ready;
        n_acc++;
      end
    end else begin
      sb.delete();
      last_g = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic new_ops(input logic which);
    if (which) begin
      req1_a = DW'($urandom); req1_b = DW'($urandom); req1_kernel = 1'($urandom);
    end else begin
      req0_a = DW'($urandom); req0_b = DW'($urandom); req0_kernel = 1'($urandom);
    end
  endtask

  int t_acc, t_out, n0, o_cnt, resumed;
  logic seen;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_kernel = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_kernel = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single request from reset: SLEEP, WAKE, accept in the third cycle.
    req0_a = 8'h03; req0_b = 8'h0F; req0_kernel = 1'b1; req0_valid = 1'b1;
    tick();
    check("rst_gate", 32'(s_gate), 0);
    check("rst_busy", 32'(s_busy), 0);
    check("rst_out_valid", 32'(s_ov), 0);
    check("rst_out_data", 32'(s_od), 0);
    check("rst_eval_in1", 32'(s_in1), 0);
    check("sleep_ready0", 32'(s_r0), 0);
    tick();
    check("wake_gate", 32'(s_gate), 1);
    check("wake_ready0", 32'(s_r0), 0);
    tick();
    check("run_ready0", 32'(s_r0), 1);
    t_acc = s_cyc;
    req0_valid = 1'b0;
    tick();
    check("latency_c1_out_valid", 32'(s_ov), 0);
    tick();
    check("latency_c2_out_valid", 32'(s_ov), 0);
    tick();
    check("single_out_valid", 32'(s_ov), 1);
    check("single_out_data", 32'(s_od), 85);
    check("single_out_src", 32'(s_osrc), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("idle_gate", 32'(s_gate), 32'(s_cyc < t_acc + 3 + IDLE));
    end

    // Same operands, kernel off, issued from SLEEP.
    req0_kernel = 1'b0; req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (s_r0) begin seen = 1'b1; t_acc = s_cyc; end
    end
    check("k0_accept_seen", 32'(seen), 1);
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (s_ov) begin seen = 1'b1; t_out = s_cyc; end
    end
    check("k0_out_seen", 32'(seen), 1);
    check("k0_latency", t_out - t_acc, 3);
    check("k0_out_data", 32'(s_od), 243);

    // A request in the last idle cycle keeps the block awake.
    while (cyc < t_acc + 10) tick();
    req1_a = 8'h11; req1_b = 8'h22; req1_kernel = 1'b1; req1_valid = 1'b1;
    tick();
    check("keepalive_gate_last_idle", 32'(s_gate), 1);
    check("keepalive_ready1", 32'(s_r1), 1);
    req1_valid = 1'b0;
    tick();
    check("keepalive_gate_after", 32'(s_gate), 1);
    repeat (4) tick();

    // Both requesters continuously valid: strict alternation, one result per cycle.
    do_reset();
    new_ops(1'b0); new_ops(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    n0 = n_acc; o_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_r0 || s_r1) check("rr_sequence", 32'(s_r1), 32'((n_acc - n0 - 1) % 2));
      if (s_ov) o_cnt++;
      if (s_r0) new_ops(1'b0);
      if (s_r1) new_ops(1'b1);
    end
    check("rr_accepts", n_acc - n0, 18);
    check("rr_outputs", o_cnt, 15);

    // Back-pressure: exactly FD accepts, then accepts resume once the FIFO drains.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_r0) new_ops(1'b0);
      if (s_r1) new_ops(1'b1);
    end
    check("stall_accepts", n_acc - n0, FD);
    out_ready = 1'b1;
    n0 = n_acc; o_cnt = 0; resumed = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_ov) o_cnt++;
      if (s_r0) new_ops(1'b0);
      if (s_r1) new_ops(1'b1);
    end
    check("drain_outputs", o_cnt, FD);
    check("accepts_resumed", 32'(n_acc - n0 > 0), 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("drain_complete", sb.size(), 0);

    // Reset with two results in flight and one queued.
    out_ready = 1'b0;
    req0_valid = 1'b1;
    n0 = n_acc;
    for (int i = 0; i < 12 && (n_acc - n0) < 3; i++) begin
      tick();
      if (s_r0) new_ops(1'b0);
    end
    req0_valid = 1'b0;
    check("prefill_accepts", n_acc - n0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_out_valid", 32'(s_ov), 0);
    check("post_rst_busy", 32'(s_busy), 0);
    check("post_rst_gate", 32'(s_gate), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_stale_out", 32'(s_ov), 0);
    end

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin new_ops(1'b0); req0_valid = 1'b1; end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin new_ops(1'b1); req1_valid = 1'b1; end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (s_r0) req0_valid = 1'b0;
      if (s_r1) req1_valid = 1'b0;
      if (i % 97 == 96) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (IDLE + 4) tick();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check("random_drain_complete", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eval_scheduler.md
Name: eval_scheduler

Overview:
- Two-requester round-robin scheduler for the single eval datapath (ROM lookup + inverted operand + add, 1-cycle registered result, kernel_enable mode select).
- Accepts operand pairs over valid/ready, issues them to the datapath, collects results into a small FIFO, and tags each result with its source.
- Owns the datapath clock-gate enable: idle periods put the datapath to sleep, and a one-cycle wake precedes the first issue.

Parameters:
- DW, 8, operand/result width.
- FIFO_DEPTH, 4, result FIFO entries; must be >= 3.
- IDLE_CYCLES, 8, consecutive idle cycles in RUN before entering SLEEP; must be >= 1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  DW  operand A, driven to eval data_in1.
- req0_b  in  DW  operand B, driven to eval data_in2.
- req0_kernel  in  1  mode, driven to eval kernel_enable.
- req1_valid, req1_ready, req1_a, req1_b, req1_kernel: same as requester 0.
- eval_data_in1  out  DW  registered operand A to the datapath.
- eval_data_in2  out  DW  registered operand B to the datapath.
- eval_kernel_enable  out  1  registered mode to the datapath.
- eval_gate_en  out  1  datapath clock-gate enable.
- eval_result  in  DW  datapath registered result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  DW  result at the FIFO head.
- out_src  out  1  requester id of the head result.
- busy  out  1  state != SLEEP, or any stage or FIFO entry occupied.

Behaviour:
- Reset:
  - state = SLEEP; all outputs 0; FIFO empty; s1_v = s2_v = 0; idle counter 0; last_grant = 1, so req0 wins the first tie.
- States:
  - SLEEP: eval_gate_en = 0; both readies 0. Either req_valid -> WAKE.
  - WAKE: eval_gate_en = 1; readies 0. Always -> RUN next cycle.
  - RUN: eval_gate_en = 1.
    - Idle counter clears on any accept, or while s1_v or s2_v is set.
    - Otherwise the counter increments.
    - When the counter = IDLE_CYCLES-1 and no req_valid: -> SLEEP, counter cleared.
    - A pending FIFO does not block SLEEP.
- Credit:
  - can_accept = (state == RUN) and (fifo_count + s1_v + s2_v < FIFO_DEPTH), using registered values only.
- Arbitration:
  - When can_accept is true, grant goes to the single valid requester.
  - If both are valid, grant goes to the one != last_grant.
  - req_ready = grant; it may depend on req_valid.
  - last_grant updates only on an accept.
- Pipeline:
  - Accept at cycle T: eval_data_in1/2, eval_kernel_enable and s1_src load at the T edge; s1_v = 1 during T+1.
  - The datapath registers the result at the end of T+1; s2_v/s2_src hold during T+2.
  - At the end of T+2, eval_result and s2_src are written to the FIFO; out_valid is visible in T+3.
  - Minimum accept-to-out_valid latency: 3 cycles. Sustained throughput: 1 per cycle when out_ready = 1.
- Operand registers:
  - eval_* hold their last value when no accept.
  - eval_kernel_enable forced to 0 when s1_v = 0.
- FIFO:
  - Pops on out_valid & out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow is impossible by credit; the bench asserts that it never occurs.
- Results are never modified, only width-truncated to DW.
- Reset mid-operation: in-flight and queued results are discarded; state returns to SLEEP.

Test Plan:
- Single request, datapath model attached:
  - Stimulus: from reset, req0 {a=0x03, b=0x0F, kernel=1}.
  - Response: SLEEP -> WAKE -> RUN; req0_ready high in cycle 3; out_valid 3 cycles later with out_data = 85 (98+240+3 mod 256), out_src = 0.
- Same operands, kernel=0 -> out_data = 243.
- Both requesters valid continuously with out_ready = 1:
  - Grants alternate 0,1,0,1.
  - out_src sequence matches; one result per cycle after fill.
- out_ready = 0 with both valid:
  - Exactly 4 accepts, then both readies stay 0.
  - Raising out_ready drains 4 results in order and accepts resume.
- Idle with IDLE_CYCLES = 8:
  - After the last result, eval_gate_en drops exactly 8 idle RUN cycles later.
  - A request one cycle before expiry keeps the block in RUN.
- rst asserted with 2 results in flight and 1 queued:
  - Next cycle out_valid = 0, busy = 0, eval_gate_en = 0.
  - No stale result emerges afterwards.
